// File: rtl/atmr_vote_monitor.sv
// Registered TMR voter with per-replica fault tracking for ATMR benchmark outputs.
// Stage 1 captures the three replica words, stage 2 votes and updates fault/error state.
module atmr_vote_monitor #(
    parameter int W      = 10,
    parameter int CNT_W  = 8,
    parameter int THRESH = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    input  logic [W-1:0]       a_i,
    input  logic [W-1:0]       b_i,
    input  logic [W-1:0]       c_i,
    input  logic               clr_i,
    output logic               out_valid,
    output logic [W-1:0]       z_o,
    output logic [2:0]         mism_o,
    output logic               uncorr_o,
    output logic [2:0]         fault_o,
    output logic [3*CNT_W-1:0] err_cnt_o
);

    localparam int RUN_W = $clog2(THRESH + 1);
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(THRESH);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic             s1_valid;
    logic [W-1:0]     s1_a;
    logic [W-1:0]     s1_b;
    logic [W-1:0]     s1_c;

    logic [W-1:0]     vote_z;
    logic             vote_unc;
    logic [2:0]       vote_mism;

    logic [RUN_W-1:0] run_q   [3];
    logic [RUN_W-1:0] run_nxt [3];
    logic [CNT_W-1:0] err_q   [3];
    logic [2:0]       cand;
    logic [2:0]       fault_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_c     <= '0;
        end else begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_a <= a_i;
                s1_b <= b_i;
                s1_c <= c_i;
            end
        end
    end

    // With two healthy replicas the lower-index one wins every disputed bit,
    // so the voted word is simply that replica.
    always_comb begin
        vote_z   = (s1_a & s1_b) | (s1_a & s1_c) | (s1_b & s1_c);
        vote_unc = 1'b0;
        case (fault_o)
            3'b000: begin
                vote_z   = (s1_a & s1_b) | (s1_a & s1_c) | (s1_b & s1_c);
                vote_unc = 1'b0;
            end
            3'b100: begin
                vote_z   = s1_a;
                vote_unc = |(s1_a ^ s1_b);
            end
            3'b010: begin
                vote_z   = s1_a;
                vote_unc = |(s1_a ^ s1_c);
            end
            3'b001: begin
                vote_z   = s1_b;
                vote_unc = |(s1_b ^ s1_c);
            end
            3'b110: begin
                vote_z   = s1_a;
                vote_unc = 1'b1;
            end
            3'b101: begin
                vote_z   = s1_b;
                vote_unc = 1'b1;
            end
            3'b011: begin
                vote_z   = s1_c;
                vote_unc = 1'b1;
            end
            default: begin
                vote_unc = 1'b1;
            end
        endcase
        vote_mism[0] = |(s1_a ^ vote_z);
        vote_mism[1] = |(s1_b ^ vote_z);
        vote_mism[2] = |(s1_c ^ vote_z);
    end

    always_comb begin
        for (int r = 0; r < 3; r++) begin
            if (!vote_mism[r])
                run_nxt[r] = '0;
            else if (run_q[r] == RUN_MAX)
                run_nxt[r] = RUN_MAX;
            else
                run_nxt[r] = run_q[r] + 1'b1;
            cand[r] = vote_mism[r] && (run_nxt[r] == RUN_MAX) && !fault_o[r];
        end
        fault_nxt = fault_o | cand;
        // Never retire the last healthy replica: lowest-index candidate survives.
        if (&fault_nxt) begin
            if (cand[0])
                fault_nxt[0] = 1'b0;
            else if (cand[1])
                fault_nxt[1] = 1'b0;
            else
                fault_nxt[2] = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fault_o <= '0;
            for (int r = 0; r < 3; r++) begin
                run_q[r] <= '0;
                err_q[r] <= '0;
            end
        end else if (clr_i) begin
            fault_o <= '0;
            for (int r = 0; r < 3; r++) begin
                run_q[r] <= '0;
                err_q[r] <= '0;
            end
        end else if (s1_valid) begin
            fault_o <= fault_nxt;
            for (int r = 0; r < 3; r++) begin
                run_q[r] <= run_nxt[r];
                if (vote_mism[r] && (err_q[r] != CNT_MAX))
                    err_q[r] <= err_q[r] + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            z_o       <= '0;
            mism_o    <= '0;
            uncorr_o  <= 1'b0;
        end else begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                z_o      <= vote_z;
                mism_o   <= vote_mism;
                uncorr_o <= vote_unc;
            end
        end
    end

    assign err_cnt_o = {err_q[2], err_q[1], err_q[0]};

endmodule

// File: tb/tb_atmr_vote_monitor.sv
// Self-checking bench for atmr_vote_monitor: directed scenarios plus randomized
// replica streams, compared against a per-sample reference model.
module tb_atmr_vote_monitor;

    localparam int W      = 10;
    localparam int THRESH = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          clr_i = 1'b0;
    logic [W-1:0]  a_i = '0;
    logic [W-1:0]  b_i = '0;
    logic [W-1:0]  c_i = '0;

    logic          out_valid, out_valid3;
    logic [W-1:0]  z_o, z3;
    logic [2:0]    mism_o, mism3;
    logic          uncorr_o, uncorr3;
    logic [2:0]    fault_o, fault3;
    logic [23:0]   err_cnt_o;
    logic [8:0]    err_cnt3;

    atmr_vote_monitor #(.W(W), .CNT_W(8), .THRESH(THRESH)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .a_i(a_i), .b_i(b_i), .c_i(c_i),
        .clr_i(clr_i), .out_valid(out_valid), .z_o(z_o), .mism_o(mism_o),
        .uncorr_o(uncorr_o), .fault_o(fault_o), .err_cnt_o(err_cnt_o)
    );

    atmr_vote_monitor #(.W(W), .CNT_W(3), .THRESH(THRESH)) dut3 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .a_i(a_i), .b_i(b_i), .c_i(c_i),
        .clr_i(clr_i), .out_valid(out_valid3), .z_o(z3), .mism_o(mism3),
        .uncorr_o(uncorr3), .fault_o(fault3), .err_cnt_o(err_cnt3)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Reference model state: sample waiting in stage 1, expected outputs, per-replica bookkeeping.
    bit           p_v;
    logic [W-1:0] p_w [3];
    bit           e_ov;
    logic [W-1:0] e_z;
    logic [2:0]   e_m;
    bit           e_u;
    bit           m_fault [3];
    int           m_run   [3];
    int           m_err   [3];

    function automatic int sat(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    task automatic model_reset();
        p_v  = 0;
        e_ov = 0;
        e_z  = '0;
        e_m  = '0;
        e_u  = 0;
        for (int r = 0; r < 3; r++) begin
            p_w[r]     = '0;
            m_fault[r] = 0;
            m_run[r]   = 0;
            m_err[r]   = 0;
        end
    endtask

    task automatic model_edge();
        int hl[$];
        int ones;
        int n_left;
        bit cand [3];
        if (rst) begin
            model_reset();
            return;
        end
        if (p_v) begin
            for (int r = 0; r < 3; r++)
                if (!m_fault[r]) hl.push_back(r);
            e_u = 0;
            for (int b = 0; b < W; b++) begin
                if (hl.size() == 3) begin
                    ones = int'(p_w[0][b]) + int'(p_w[1][b]) + int'(p_w[2][b]);
                    e_z[b] = (ones >= 2);
                end else if (hl.size() == 2) begin
                    e_z[b] = p_w[hl[0]][b];
                    if (p_w[hl[0]][b] != p_w[hl[1]][b]) e_u = 1;
                end else begin
                    e_z[b] = p_w[hl[0]][b];
                    e_u = 1;
                end
            end
            for (int r = 0; r < 3; r++) e_m[r] = (p_w[r] != e_z);
            e_ov = 1;
            if (!clr_i) begin
                for (int r = 0; r < 3; r++) begin
                    if (e_m[r]) begin
                        m_err[r]++;
                        m_run[r] = sat(m_run[r] + 1, THRESH);
                    end else begin
                        m_run[r] = 0;
                    end
                    cand[r] = e_m[r] && (m_run[r] == THRESH) && !m_fault[r];
                end
                n_left = 0;
                for (int r = 0; r < 3; r++) if (!(m_fault[r] || cand[r])) n_left++;
                if (n_left == 0) begin
                    for (int r = 0; r < 3; r++)
                        if (cand[r]) begin
                            cand[r] = 0;
                            break;
                        end
                end
                for (int r = 0; r < 3; r++) if (cand[r]) m_fault[r] = 1;
            end
        end else begin
            e_ov = 0;
        end
        if (clr_i) begin
            for (int r = 0; r < 3; r++) begin
                m_run[r]   = 0;
                m_err[r]   = 0;
                m_fault[r] = 0;
            end
        end
        p_v    = in_valid;
        p_w[0] = a_i;
        p_w[1] = b_i;
        p_w[2] = c_i;
    endtask

    task automatic compare_all();
        logic [23:0] exp_err;
        logic [8:0]  exp_err3;
        exp_err  = '0;
        exp_err3 = '0;
        for (int r = 0; r < 3; r++) begin
            exp_err[8*r +: 8]  = 8'(sat(m_err[r], 255));
            exp_err3[3*r +: 3] = 3'(sat(m_err[r], 7));
        end
        check_eq("out_valid", out_valid, e_ov);
        check_eq("z_o", z_o, e_z);
        check_eq("mism_o", mism_o, e_m);
        check_eq("uncorr_o", uncorr_o, e_u);
        check_eq("fault_o", fault_o, {m_fault[2], m_fault[1], m_fault[0]});
        check_eq("err_cnt_o", err_cnt_o, exp_err);
        check_eq("err_cnt_o_w3", err_cnt3, exp_err3);
    endtask

    task automatic step(input bit v, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] c, input bit clr);
        in_valid = v;
        a_i      = a;
        b_i      = b;
        c_i      = c;
        clr_i    = clr;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare_all();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish, got running expected done");
        $fatal(1);
    end

    initial begin
        int bad;
        logic [W-1:0] base;
        logic [W-1:0] w [3];
        bit v;
        bit clr;

        model_reset();
        rst = 1'b1;
        step(0, '0, '0, '0, 0);
        step(1, 10'h155, 10'h155, 10'h155, 0);
        check_eq("reset_out_valid", out_valid, 0);
        check_eq("reset_err", err_cnt_o, 0);
        rst = 1'b0;

        // agreement
        step(1, 10'h2A5, 10'h2A5, 10'h2A5, 0);
        check_eq("agree_first_ov", out_valid, 0);
        step(1, 10'h2A5, 10'h2A5, 10'h2A5, 0);
        check_eq("agree_ov", out_valid, 1);
        check_eq("agree_z", z_o, 10'h2A5);
        step(1, 10'h2A5, 10'h2A5, 10'h2A5, 0);

        // single fault on C
        for (int i = 0; i < 4; i++) step(1, 10'h2A5, 10'h2A5, 10'h2A4, 0);
        step(1, 10'h2A5, 10'h2A5, 10'h2A5, 0);
        check_eq("single_fault_flag", fault_o, 3'b100);
        check_eq("single_fault_mism", mism_o, 3'b100);
        check_eq("single_fault_cnt_c", err_cnt_o[23:16], 4);

        // degraded vote with C retired
        step(1, 10'h001, 10'h000, 10'h2A5, 0);
        check_eq("recover_mism", mism_o, 3'b000);
        for (int i = 0; i < 3; i++) step(1, 10'h001, 10'h000, 10'h2A5, 0);
        step(1, 10'h3FF, 10'h000, 10'h2A5, 0);
        check_eq("degraded_fault", fault_o, 3'b110);
        check_eq("degraded_z", z_o, 10'h001);
        check_eq("degraded_mism", mism_o, 3'b110);
        check_eq("degraded_unc", uncorr_o, 1);

        // clear at the edge presenting a mismatching sample
        step(0, '0, '0, '0, 1);
        check_eq("clr_z", z_o, 10'h3FF);
        check_eq("clr_unc", uncorr_o, 1);
        check_eq("clr_fault", fault_o, 3'b000);
        check_eq("clr_err", err_cnt_o, 0);

        // triple disagreement
        for (int i = 0; i < 5; i++) step(1, 10'h001, 10'h002, 10'h004, 0);
        check_eq("triple_fault", fault_o, 3'b110);
        check_eq("triple_mism", mism_o, 3'b111);
        check_eq("triple_z", z_o, 10'h000);
        step(0, '0, '0, '0, 0);
        check_eq("triple_sole_z", z_o, 10'h001);

        // saturation: 9 mismatches on C
        rst = 1'b1;
        step(0, '0, '0, '0, 0);
        rst = 1'b0;
        for (int i = 0; i < 9; i++) step(1, 10'h000, 10'h000, 10'h001, 0);
        step(0, '0, '0, '0, 0);
        check_eq("sat_cnt3_c", err_cnt3[8:6], 7);
        check_eq("sat_cnt8_c", err_cnt_o[23:16], 9);

        // asynchronous reset mid-stream
        step(1, 10'h0F0, 10'h0F0, 10'h0F1, 0);
        step(1, 10'h0F0, 10'h0F0, 10'h0F1, 0);
        rst = 1'b1;
        #1;
        check_eq("rst_async_ov", out_valid, 0);
        check_eq("rst_async_fault", fault_o, 0);
        check_eq("rst_async_err", err_cnt_o, 0);
        model_reset();
        step(1, 10'h0AA, 10'h0AA, 10'h0AA, 0);
        rst = 1'b0;
        step(0, '0, '0, '0, 0);
        check_eq("rst_discard_ov", out_valid, 0);

        // randomized streams
        bad = 3;
        for (int n = 0; n < 1500; n++) begin
            if (n % 150 == 0) bad = $urandom_range(0, 3);
            base = W'($urandom);
            for (int r = 0; r < 3; r++) begin
                w[r] = base;
                if ($urandom_range(0, 7) == 0) w[r] = w[r] ^ W'($urandom);
                if (r == bad && $urandom_range(0, 5) != 0)
                    w[r] = w[r] ^ (W'(1) << $urandom_range(0, W - 1));
            end
            v   = ($urandom_range(0, 3) != 0);
            clr = ($urandom_range(0, 63) == 0);
            step(v, w[0], w[1], w[2], clr);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
